ysyx_22041211_lsu: RTL and testbench

//   Load/store unit: initiator side of the data-SRAM port. Accepts one memory op from EXU via valid/ready,

---
 rtl/ysyx_22041211_lsu_pkg.sv | 45 ++++
 rtl/ysyx_22041211_lsu_align.sv | 46 ++++
 rtl/ysyx_22041211_lsu.sv | 176 +++++++++++++++++
 tb/tb_ysyx_22041211_lsu.sv | 413 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ysyx_22041211_lsu_pkg.sv
// Shared constants for the load/store unit: funct3 codes, byte masks, FSM states and error codes.
package ysyx_22041211_lsu_pkg;

  // RV32 load funct3 codes
  localparam logic [2:0] Funct3Lb  = 3'b000;
  localparam logic [2:0] Funct3Lh  = 3'b001;
  localparam logic [2:0] Funct3Lw  = 3'b010;
  localparam logic [2:0] Funct3Lbu = 3'b100;
  localparam logic [2:0] Funct3Lhu = 3'b101;

  // RV32 store funct3 codes
  localparam logic [2:0] Funct3Sb = 3'b000;
  localparam logic [2:0] Funct3Sh = 3'b001;
  localparam logic [2:0] Funct3Sw = 3'b010;

  // Byte masks are unshifted; the memory aligns them with the address
  localparam logic [7:0] MaskByte = 8'h01;
  localparam logic [7:0] MaskHalf = 8'h03;
  localparam logic [7:0] MaskWord = 8'h0F;

  typedef enum logic [1:0] {
    StIdle,
    StRead,
    StWrite,
    StResp
  } lsu_state_e;

  typedef enum logic [1:0] {
    ErrOk       = 2'b00,
    ErrMisalign = 2'b01,
    ErrIllegal  = 2'b10,
    ErrTimeout  = 2'b11
  } lsu_err_e;

  // funct3[1:0] encodes the access size for both loads and stores
  function automatic logic [7:0] size_mask(input logic [1:0] size);
    case (size)
      2'b00:   size_mask = MaskByte;
      2'b01:   size_mask = MaskHalf;
      2'b10:   size_mask = MaskWord;
      default: size_mask = 8'h00;
    endcase
  endfunction

endpackage

// File: rtl/ysyx_22041211_lsu_align.sv
// Combinational helpers: op legality, size mask, misalignment and load-data extension.
module ysyx_22041211_lsu_align
  import ysyx_22041211_lsu_pkg::*;
#(
  parameter int unsigned DATA_LEN = 32
) (
  input  logic [2:0]          funct3,
  input  logic [1:0]          addr_lo,
  input  logic                load,
  input  logic                store,
  output logic [7:0]          mask,
  output logic                misalign,
  output logic                illegal,
  input  logic [2:0]          ext_funct3,
  input  logic [DATA_LEN-1:0] ext_rdata,
  output logic [DATA_LEN-1:0] ext_data
);

  logic load_f3_ok;
  logic store_f3_ok;

  // Decode legality, access size and alignment of the incoming op
  always_comb begin
    load_f3_ok  = funct3 inside {Funct3Lb, Funct3Lh, Funct3Lw, Funct3Lbu, Funct3Lhu};
    store_f3_ok = funct3 inside {Funct3Sb, Funct3Sh, Funct3Sw};
    illegal     = (load & store) | (load & ~load_f3_ok) | (store & ~store_f3_ok);
    mask        = size_mask(funct3[1:0]);
    case (funct3[1:0])
      2'b01:   misalign = addr_lo[0];
      2'b10:   misalign = |addr_lo;
      default: misalign = 1'b0;
    endcase
  end

  // Sign/zero-extend right-justified read data; bits above the access size are ignored
  always_comb begin
    case (ext_funct3)
      Funct3Lb:  ext_data = {{(DATA_LEN - 8){ext_rdata[7]}}, ext_rdata[7:0]};
      Funct3Lh:  ext_data = {{(DATA_LEN - 16){ext_rdata[15]}}, ext_rdata[15:0]};
      Funct3Lbu: ext_data = {{(DATA_LEN - 8){1'b0}}, ext_rdata[7:0]};
      Funct3Lhu: ext_data = {{(DATA_LEN - 16){1'b0}}, ext_rdata[15:0]};
      default:   ext_data = ext_rdata;
    endcase
  end

endmodule

// File: rtl/ysyx_22041211_lsu.sv
// Load/store unit: accepts one op from EXU, runs the data-SRAM handshake, returns the result to WBU.
module ysyx_22041211_lsu
  import ysyx_22041211_lsu_pkg::*;
#(
  parameter int unsigned ADDR_LEN = 32,
  parameter int unsigned DATA_LEN = 32,
  parameter int unsigned TIMEOUT  = 255
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                lsu_valid_i,
  output logic                lsu_ready_o,
  input  logic                lsu_load_i,
  input  logic                lsu_store_i,
  input  logic [2:0]          lsu_funct3_i,
  input  logic [ADDR_LEN-1:0] lsu_addr_i,
  input  logic [DATA_LEN-1:0] lsu_wdata_i,
  output logic                lsu_valid_o,
  input  logic                lsu_ready_i,
  output logic [DATA_LEN-1:0] lsu_rdata_o,
  output logic [1:0]          lsu_err_o,
  output logic                mem_ren_o,
  output logic [ADDR_LEN-1:0] mem_raddr_o,
  output logic [7:0]          mem_rmask_o,
  input  logic                mem_rvalid_i,
  input  logic [DATA_LEN-1:0] mem_rdata_i,
  output logic                mem_wen_o,
  output logic [ADDR_LEN-1:0] mem_waddr_o,
  output logic [DATA_LEN-1:0] mem_wdata_o,
  output logic [7:0]          mem_wmask_o,
  input  logic                mem_bvalid_i
);

  // Last waiting cycle before the request is abandoned
  localparam logic [7:0] TimeoutLast = 8'(TIMEOUT - 1);

  lsu_state_e          state_q;
  logic [7:0]          cnt_q;
  logic [2:0]          funct3_q;
  logic                valid_q;
  logic [DATA_LEN-1:0] rdata_q;
  logic [1:0]          err_q;
  logic                ren_q;
  logic [ADDR_LEN-1:0] raddr_q;
  logic [7:0]          rmask_q;
  logic                wen_q;
  logic [ADDR_LEN-1:0] waddr_q;
  logic [DATA_LEN-1:0] wdata_q;
  logic [7:0]          wmask_q;

  logic [7:0]          chk_mask;
  logic                chk_misalign;
  logic                chk_illegal;
  logic [DATA_LEN-1:0] ext_data;
  logic                accept;

  ysyx_22041211_lsu_align #(
    .DATA_LEN (DATA_LEN)
  ) u_align (
    .funct3     (lsu_funct3_i),
    .addr_lo    (lsu_addr_i[1:0]),
    .load       (lsu_load_i),
    .store      (lsu_store_i),
    .mask       (chk_mask),
    .misalign   (chk_misalign),
    .illegal    (chk_illegal),
    .ext_funct3 (funct3_q),
    .ext_rdata  (mem_rdata_i),
    .ext_data   (ext_data)
  );

  assign lsu_ready_o = (state_q == StIdle);
  assign accept      = lsu_valid_i & lsu_ready_o;

  assign lsu_valid_o = valid_q;
  assign lsu_rdata_o = rdata_q;
  assign lsu_err_o   = err_q;
  assign mem_ren_o   = ren_q;
  assign mem_raddr_o = raddr_q;
  assign mem_rmask_o = rmask_q;
  assign mem_wen_o   = wen_q;
  assign mem_waddr_o = waddr_q;
  assign mem_wdata_o = wdata_q;
  assign mem_wmask_o = wmask_q;

  // Op sequencing: request registers, response registers and the timeout counter
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      funct3_q <= '0;
      valid_q  <= 1'b0;
      rdata_q  <= '0;
      err_q    <= ErrOk;
      ren_q    <= 1'b0;
      raddr_q  <= '0;
      rmask_q  <= '0;
      wen_q    <= 1'b0;
      waddr_q  <= '0;
      wdata_q  <= '0;
      wmask_q  <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (accept) begin
            funct3_q <= lsu_funct3_i;
            rdata_q  <= '0;
            err_q    <= ErrOk;
            cnt_q    <= '0;
            if (chk_illegal) begin
              state_q <= StResp;
              valid_q <= 1'b1;
              err_q   <= ErrIllegal;
            end else if (chk_misalign) begin
              state_q <= StResp;
              valid_q <= 1'b1;
              err_q   <= ErrMisalign;
            end else if (lsu_load_i) begin
              state_q <= StRead;
              ren_q   <= 1'b1;
              raddr_q <= lsu_addr_i;
              rmask_q <= chk_mask;
            end else if (lsu_store_i) begin
              state_q <= StWrite;
              wen_q   <= 1'b1;
              waddr_q <= lsu_addr_i;
              wdata_q <= lsu_wdata_i;
              wmask_q <= chk_mask;
            end else begin
              // Neither load nor store: pass through with a zero result
              state_q <= StResp;
              valid_q <= 1'b1;
            end
          end
        end
        StRead: begin
          if (mem_rvalid_i) begin
            state_q <= StResp;
            valid_q <= 1'b1;
            rdata_q <= ext_data;
            ren_q   <= 1'b0;
          end else if (cnt_q == TimeoutLast) begin
            state_q <= StResp;
            valid_q <= 1'b1;
            err_q   <= ErrTimeout;
            ren_q   <= 1'b0;
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
        end
        StWrite: begin
          if (mem_bvalid_i) begin
            state_q <= StResp;
            valid_q <= 1'b1;
            wen_q   <= 1'b0;
          end else if (cnt_q == TimeoutLast) begin
            state_q <= StResp;
            valid_q <= 1'b1;
            err_q   <= ErrTimeout;
            wen_q   <= 1'b0;
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
        end
        StResp: begin
          if (lsu_ready_i) begin
            state_q <= StIdle;
            valid_q <= 1'b0;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_ysyx_22041211_lsu.sv
// Self-checking bench for the LSU: directed pins plus randomized ops against a behavioural model.
module tb_ysyx_22041211_lsu;

  localparam int Timeout = 255;
  localparam int PhIdle  = 0;
  localparam int PhMem   = 1;
  localparam int PhResp  = 2;

  logic        clk;
  logic        rst;
  logic        lsu_valid_i;
  logic        lsu_ready_o;
  logic        lsu_load_i;
  logic        lsu_store_i;
  logic [2:0]  lsu_funct3_i;
  logic [31:0] lsu_addr_i;
  logic [31:0] lsu_wdata_i;
  logic        lsu_valid_o;
  logic        lsu_ready_i;
  logic [31:0] lsu_rdata_o;
  logic [1:0]  lsu_err_o;
  logic        mem_ren_o;
  logic [31:0] mem_raddr_o;
  logic [7:0]  mem_rmask_o;
  logic        mem_rvalid_i;
  logic [31:0] mem_rdata_i;
  logic        mem_wen_o;
  logic [31:0] mem_waddr_o;
  logic [31:0] mem_wdata_o;
  logic [7:0]  mem_wmask_o;
  logic        mem_bvalid_i;

  int checks;
  int errors;

  // Memory responder configuration and observations
  int          mem_wait;
  logic [31:0] mem_data;
  int          total_req_cycles;
  logic [31:0] last_raddr;
  logic [7:0]  last_rmask;
  logic [31:0] last_waddr;
  logic [31:0] last_wdata;
  logic [7:0]  last_wmask;

  // Behavioural model state
  int          m_phase;
  int          m_cnt;
  logic        m_load;
  logic [2:0]  m_f3;
  logic [31:0] m_addr;
  logic [31:0] m_wdata;
  logic [7:0]  m_mask;
  logic [31:0] m_rdata;
  logic [1:0]  m_err;

  ysyx_22041211_lsu dut (
    .clk          (clk),
    .rst          (rst),
    .lsu_valid_i  (lsu_valid_i),
    .lsu_ready_o  (lsu_ready_o),
    .lsu_load_i   (lsu_load_i),
    .lsu_store_i  (lsu_store_i),
    .lsu_funct3_i (lsu_funct3_i),
    .lsu_addr_i   (lsu_addr_i),
    .lsu_wdata_i  (lsu_wdata_i),
    .lsu_valid_o  (lsu_valid_o),
    .lsu_ready_i  (lsu_ready_i),
    .lsu_rdata_o  (lsu_rdata_o),
    .lsu_err_o    (lsu_err_o),
    .mem_ren_o    (mem_ren_o),
    .mem_raddr_o  (mem_raddr_o),
    .mem_rmask_o  (mem_rmask_o),
    .mem_rvalid_i (mem_rvalid_i),
    .mem_rdata_i  (mem_rdata_i),
    .mem_wen_o    (mem_wen_o),
    .mem_waddr_o  (mem_waddr_o),
    .mem_wdata_o  (mem_wdata_o),
    .mem_wmask_o  (mem_wmask_o),
    .mem_bvalid_i (mem_bvalid_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Load extension from the ISA rules, done with integer arithmetic
  function automatic logic [31:0] model_ext(input logic [2:0] f3, input logic [31:0] d);
    int v;
    case (f3)
      3'd0: begin v = int'(d & 32'hFF);   if (v >= 128)   v = v - 256;   return 32'(v); end
      3'd1: begin v = int'(d & 32'hFFFF); if (v >= 32768) v = v - 65536; return 32'(v); end
      3'd4: return d & 32'hFF;
      3'd5: return d & 32'hFFFF;
      default: return d;
    endcase
  endfunction

  // Model: what the LSU must be doing in the cycle after each edge
  initial begin
    int  sz;
    bit  ld_ok;
    bit  st_ok;
    m_phase = PhIdle;
    m_cnt = 0;
    m_load = 1'b0;
    m_f3 = '0;
    m_addr = '0;
    m_wdata = '0;
    m_mask = '0;
    m_rdata = '0;
    m_err = '0;
    forever begin
      @(posedge clk or negedge rst);
      if (!rst) begin
        m_phase = PhIdle;
      end else if (m_phase == PhIdle) begin
        if (lsu_valid_i) begin
          m_load  = lsu_load_i;
          m_f3    = lsu_funct3_i;
          m_addr  = lsu_addr_i;
          m_wdata = lsu_wdata_i;
          m_rdata = '0;
          m_err   = 2'd0;
          ld_ok   = lsu_funct3_i inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
          st_ok   = lsu_funct3_i inside {3'd0, 3'd1, 3'd2};
          sz      = (lsu_funct3_i[1:0] == 2'd1) ? 2 : (lsu_funct3_i[1:0] == 2'd2) ? 4 : 1;
          m_mask  = 8'((1 << sz) - 1);
          m_phase = PhResp;
          if ((lsu_load_i && lsu_store_i) || (lsu_load_i && !ld_ok) || (lsu_store_i && !st_ok))
            m_err = 2'd2;
          else if ((lsu_addr_i % 32'(sz)) != 0)
            m_err = 2'd1;
          else if (lsu_load_i || lsu_store_i) begin
            m_phase = PhMem;
            m_cnt   = 0;
          end
        end
      end else if (m_phase == PhMem) begin
        m_cnt++;
        if (m_load ? mem_rvalid_i : mem_bvalid_i) begin
          m_phase = PhResp;
          m_rdata = m_load ? model_ext(m_f3, mem_rdata_i) : 32'd0;
        end else if (m_cnt == Timeout) begin
          m_phase = PhResp;
          m_err   = 2'd3;
        end
      end else begin
        if (lsu_ready_i) m_phase = PhIdle;
      end
    end
  end

  // Compare: every cycle, mid-cycle, DUT outputs against the model
  initial begin
    forever begin
      @(negedge clk);
      chk("ready_o", 32'(lsu_ready_o), 32'(m_phase == PhIdle));
      chk("valid_o", 32'(lsu_valid_o), 32'(m_phase == PhResp));
      chk("mem_ren", 32'(mem_ren_o), 32'(m_phase == PhMem && m_load));
      chk("mem_wen", 32'(mem_wen_o), 32'(m_phase == PhMem && !m_load));
      if (m_phase == PhMem && m_load) begin
        chk("raddr", mem_raddr_o, m_addr);
        chk("rmask", 32'(mem_rmask_o), 32'(m_mask));
      end
      if (m_phase == PhMem && !m_load) begin
        chk("waddr", mem_waddr_o, m_addr);
        chk("wdata", mem_wdata_o, m_wdata);
        chk("wmask", 32'(mem_wmask_o), 32'(m_mask));
      end
      if (m_phase == PhResp) begin
        chk("rdata", lsu_rdata_o, m_rdata);
        chk("err", 32'(lsu_err_o), 32'(m_err));
      end
    end
  end

  // Memory responder: answers after mem_wait stall cycles, garbage data otherwise
  initial begin
    int cnt;
    cnt = 0;
    total_req_cycles = 0;
    mem_rvalid_i = 1'b0;
    mem_bvalid_i = 1'b0;
    mem_rdata_i = '0;
    last_raddr = '0;
    last_rmask = '0;
    last_waddr = '0;
    last_wdata = '0;
    last_wmask = '0;
    forever begin
      @(posedge clk);
      #1;
      if (mem_ren_o || mem_wen_o) begin
        cnt++;
        total_req_cycles++;
        if (mem_ren_o) begin
          last_raddr = mem_raddr_o;
          last_rmask = mem_rmask_o;
        end else begin
          last_waddr = mem_waddr_o;
          last_wdata = mem_wdata_o;
          last_wmask = mem_wmask_o;
        end
        mem_rvalid_i = mem_ren_o && (cnt > mem_wait);
        mem_bvalid_i = mem_wen_o && (cnt > mem_wait);
      end else begin
        cnt = 0;
        mem_rvalid_i = 1'b0;
        mem_bvalid_i = 1'b0;
      end
      mem_rdata_i = mem_rvalid_i ? mem_data : $urandom;
    end
  end

  // Issue one op from an idle DUT at posedge+1; returns result, latency and request cycles
  task automatic run_op(input logic ld, input logic st, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] wd, input logic [31:0] md,
                        input int wt, input int hold, output logic [31:0] rd,
                        output logic [1:0] er, output int lat, output int reqc);
    int start;
    start        = total_req_cycles;
    mem_wait     = wt;
    mem_data     = md;
    lsu_valid_i  = 1'b1;
    lsu_load_i   = ld;
    lsu_store_i  = st;
    lsu_funct3_i = f3;
    lsu_addr_i   = addr;
    lsu_wdata_i  = wd;
    @(posedge clk);
    #1;
    lat = 1;
    while (!lsu_valid_o && lat < 400) begin
      lsu_valid_i  = 1'($urandom);
      lsu_load_i   = 1'($urandom);
      lsu_store_i  = 1'($urandom);
      lsu_funct3_i = 3'($urandom);
      lsu_addr_i   = $urandom;
      @(posedge clk);
      #1;
      lat++;
    end
    chk("wait_valid", 32'(lsu_valid_o), 32'd1);
    rd = lsu_rdata_o;
    er = lsu_err_o;
    repeat (hold) begin
      lsu_valid_i = 1'($urandom);
      lsu_addr_i  = $urandom;
      @(posedge clk);
      #1;
    end
    lsu_ready_i = 1'b1;
    lsu_valid_i = 1'b0;
    @(posedge clk);
    #1;
    lsu_ready_i = 1'b0;
    reqc = total_req_cycles - start;
  endtask

  initial begin
    logic [31:0] rd;
    logic [1:0]  er;
    int          lat;
    int          reqc;
    int          kind;
    logic        ld;
    logic        st;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [2:0]  ld_f3s [5];
    logic [2:0]  st_f3s [3];
    ld_f3s = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
    st_f3s = '{3'd0, 3'd1, 3'd2};
    checks = 0;
    errors = 0;
    rst = 1'b0;
    lsu_valid_i = 1'b0;
    lsu_load_i = 1'b0;
    lsu_store_i = 1'b0;
    lsu_funct3_i = '0;
    lsu_addr_i = '0;
    lsu_wdata_i = '0;
    lsu_ready_i = 1'b0;
    mem_wait = 0;
    mem_data = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready", 32'(lsu_ready_o), 32'd1);
    chk("rst_valid", 32'(lsu_valid_o), 32'd0);
    chk("rst_ren", 32'(mem_ren_o), 32'd0);
    chk("rst_wen", 32'(mem_wen_o), 32'd0);
    chk("rst_raddr", mem_raddr_o, 32'd0);
    chk("rst_rmask", 32'(mem_rmask_o), 32'd0);
    chk("rst_waddr", mem_waddr_o, 32'd0);
    chk("rst_wdata", mem_wdata_o, 32'd0);
    chk("rst_wmask", 32'(mem_wmask_o), 32'd0);
    chk("rst_rdata", lsu_rdata_o, 32'd0);
    chk("rst_err", 32'(lsu_err_o), 32'd0);
    #2;
    rst = 1'b1;
    @(posedge clk);
    #1;

    // LW, zero-wait memory
    run_op(1'b1, 1'b0, 3'b010, 32'h8000_0010, 32'd0, 32'hDEAD_BEEF, 0, 0, rd, er, lat, reqc);
    chk("lw_rdata", rd, 32'hDEAD_BEEF);
    chk("lw_err", 32'(er), 32'd0);
    chk("lw_latency", 32'(lat), 32'd2);
    chk("lw_raddr", last_raddr, 32'h8000_0010);
    chk("lw_rmask", 32'(last_rmask), 32'h0F);

    // LB vs LBU vs LH extension
    run_op(1'b1, 1'b0, 3'b000, 32'h8000_0003, 32'd0, 32'h0000_0080, 0, 0, rd, er, lat, reqc);
    chk("lb_rdata", rd, 32'hFFFF_FF80);
    chk("lb_rmask", 32'(last_rmask), 32'h01);
    run_op(1'b1, 1'b0, 3'b100, 32'h8000_0003, 32'd0, 32'h0000_0080, 1, 0, rd, er, lat, reqc);
    chk("lbu_rdata", rd, 32'h0000_0080);
    run_op(1'b1, 1'b0, 3'b001, 32'h8000_0002, 32'd0, 32'hABCD_8001, 2, 0, rd, er, lat, reqc);
    chk("lh_rdata", rd, 32'hFFFF_8001);
    chk("lh_rmask", 32'(last_rmask), 32'h03);

    // SH with three stall cycles
    run_op(1'b0, 1'b1, 3'b001, 32'h8000_0002, 32'h1234_ABCD, 32'd0, 3, 0, rd, er, lat, reqc);
    chk("sh_wen_cycles", 32'(reqc), 32'd4);
    chk("sh_wmask", 32'(last_wmask), 32'h03);
    chk("sh_wdata", last_wdata, 32'h1234_ABCD);
    chk("sh_waddr", last_waddr, 32'h8000_0002);
    chk("sh_err", 32'(er), 32'd0);
    chk("sh_rdata", rd, 32'd0);

    // Misaligned SW never reaches memory
    run_op(1'b0, 1'b1, 3'b010, 32'h8000_0006, 32'h5555_AAAA, 32'd0, 0, 0, rd, er, lat, reqc);
    chk("sw_mis_err", 32'(er), 32'd1);
    chk("sw_mis_wen_cycles", 32'(reqc), 32'd0);
    chk("sw_mis_latency", 32'(lat), 32'd1);

    // Illegal load funct3
    run_op(1'b1, 1'b0, 3'b011, 32'h8000_0000, 32'd0, 32'd0, 0, 0, rd, er, lat, reqc);
    chk("ld_ill_err", 32'(er), 32'd2);
    chk("ld_ill_ren_cycles", 32'(reqc), 32'd0);

    // Memory never answers
    run_op(1'b1, 1'b0, 3'b010, 32'h8000_0040, 32'd0, 32'd0, 100000, 0, rd, er, lat, reqc);
    chk("to_err", 32'(er), 32'd3);
    chk("to_rdata", rd, 32'd0);
    chk("to_ren_cycles", 32'(reqc), 32'(Timeout));
    chk("to_latency", 32'(lat), 32'(Timeout + 1));
    chk("to_ren_dropped", 32'(mem_ren_o), 32'd0);

    // Result held by WBU for five cycles
    run_op(1'b1, 1'b0, 3'b101, 32'h8000_0022, 32'd0, 32'h0000_F00D, 0, 5, rd, er, lat, reqc);
    chk("hold_rdata", rd, 32'h0000_F00D);

    // Reset during a stalled write
    mem_wait     = 100000;
    lsu_valid_i  = 1'b1;
    lsu_load_i   = 1'b0;
    lsu_store_i  = 1'b1;
    lsu_funct3_i = 3'b010;
    lsu_addr_i   = 32'h8000_0020;
    lsu_wdata_i  = 32'hCAFE_F00D;
    @(posedge clk);
    #1;
    lsu_valid_i = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    chk("rst_mid_pre_wen", 32'(mem_wen_o), 32'd1);
    rst = 1'b0;
    #1;
    chk("rst_mid_wen", 32'(mem_wen_o), 32'd0);
    chk("rst_mid_valid", 32'(lsu_valid_o), 32'd0);
    #2;
    rst = 1'b1;
    repeat (5) begin
      @(posedge clk);
      #1;
      chk("rst_mid_no_resp", 32'(lsu_valid_o), 32'd0);
      chk("rst_mid_ready", 32'(lsu_ready_o), 32'd1);
    end

    // Randomized ops; the compare process checks each cycle
    for (int i = 0; i < 80; i++) begin
      kind = int'($urandom_range(0, 9));
      addr = 32'h8000_0000 | (32'($urandom_range(0, 255)) << 2);
      if ($urandom_range(0, 2) == 0) addr = addr | 32'($urandom_range(0, 3));
      if (kind <= 3) begin
        ld = 1'b1; st = 1'b0; f3 = ld_f3s[$urandom_range(0, 4)];
      end else if (kind <= 6) begin
        ld = 1'b0; st = 1'b1; f3 = st_f3s[$urandom_range(0, 2)];
      end else if (kind == 7) begin
        ld = 1'($urandom); st = ~ld | 1'($urandom);
        f3 = 3'($urandom_range(3, 7));
      end else begin
        ld = 1'b0; st = 1'b0; f3 = 3'($urandom); addr = addr & ~32'd3;
      end
      run_op(ld, st, f3, addr, $urandom, $urandom, int'($urandom_range(0, 4)),
             int'($urandom_range(0, 3)), rd, er, lat, reqc);
      if (er != 2'd0 || (!ld && !st)) chk("rand_fault_no_mem", 32'(reqc), 32'd0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
